// File: rtl/decode_rf_issue.sv
// Decode/issue stage: drives id2rf reads and the rf write passthrough, and tracks pending rd
// writes in a scoreboard. Optional macro WB_BYPASS_EN resolves RAW hazards in the writeback cycle.
module decode_rf_issue #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   if_valid_i,
    input  logic [XLEN-1:0]        if_instr_i,
    output logic                   id_ready_o,
    output logic [4:0]             id2rf_rs1_addr_o,
    output logic [4:0]             id2rf_rs2_addr_o,
    input  logic [XLEN-1:0]        rf2id_rs1_data_i,
    input  logic [XLEN-1:0]        rf2id_rs2_data_i,
    output logic                   id2rf_rd_wr_req_o,
    output logic [4:0]             id2rf_rd_addr_o,
    output logic [XLEN-1:0]        id2rf_rd_data_o,
    input  logic                   wb_valid_i,
    input  logic [4:0]             wb_rd_addr_i,
    input  logic [XLEN-1:0]        wb_data_i,
    output logic                   ex_valid_o,
    input  logic                   ex_ready_i,
    output logic [XLEN-1:0]        ex_instr_o,
    output logic [XLEN-1:0]        ex_rs1_data_o,
    output logic [XLEN-1:0]        ex_rs2_data_o,
    output logic                   ex_rd_we_o,
    output logic                   ex_illegal_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    logic [4:0] rs1, rs2, rd;
    logic [6:0] opcode;
    logic       use1, use2, we, illegal;

    assign rs1    = if_instr_i[19:15];
    assign rs2    = if_instr_i[24:20];
    assign rd     = if_instr_i[11:7];
    assign opcode = if_instr_i[6:0];

    always_comb begin
        use1    = 1'b0;
        use2    = 1'b0;
        we      = 1'b0;
        illegal = 1'b0;
        unique case (opcode)
            7'b0110011: begin
                use1 = 1'b1;
                use2 = 1'b1;
                we   = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                use1 = 1'b1;
                we   = 1'b1;
            end
            7'b0100011, 7'b1100011: begin
                use1 = 1'b1;
                use2 = 1'b1;
            end
            7'b0110111, 7'b0010111, 7'b1101111: begin
                we = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign id2rf_rs1_addr_o = (if_valid_i && use1) ? rs1 : 5'd0;
    assign id2rf_rs2_addr_o = (if_valid_i && use2) ? rs2 : 5'd0;

    assign id2rf_rd_wr_req_o = wb_valid_i;
    assign id2rf_rd_addr_o   = wb_rd_addr_i;
    assign id2rf_rd_data_o   = wb_data_i;

    logic [31:0] sb_q, sb_d;
    logic [31:0] pend;

    always_comb begin
        pend = sb_q;
`ifdef WB_BYPASS_EN
        // A register retiring this cycle is already readable via the bypass mux.
        if (wb_valid_i) pend[wb_rd_addr_i] = 1'b0;
`endif
        pend[0] = 1'b0;
    end

    logic hazard, accept;
    assign hazard = if_valid_i && ((use1 && pend[rs1]) || (use2 && pend[rs2]) ||
                                   (we && pend[rd]));
    assign id_ready_o = !hazard && (!ex_valid_o || ex_ready_i);
    assign accept     = if_valid_i && id_ready_o;

    always_comb begin
        sb_d = sb_q;
        if (wb_valid_i) sb_d[wb_rd_addr_i] = 1'b0;
        // Set after clear so a same-index set wins.
        if (accept && we && rd != 5'd0) sb_d[rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    logic [XLEN-1:0] op1, op2;
    always_comb begin
        op1 = rf2id_rs1_data_i;
        op2 = rf2id_rs2_data_i;
`ifdef WB_BYPASS_EN
        if (wb_valid_i && wb_rd_addr_i == rs1 && rs1 != 5'd0) op1 = wb_data_i;
        if (wb_valid_i && wb_rd_addr_i == rs2 && rs2 != 5'd0) op2 = wb_data_i;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_q          <= '0;
            ex_valid_o    <= 1'b0;
            ex_instr_o    <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_rd_we_o    <= 1'b0;
            ex_illegal_o  <= 1'b0;
            stall_cnt_o   <= '0;
        end else begin
            sb_q <= sb_d;
            if (accept) begin
                ex_valid_o    <= 1'b1;
                ex_instr_o    <= if_instr_i;
                ex_rs1_data_o <= op1;
                ex_rs2_data_o <= op2;
                ex_rd_we_o    <= we && (rd != 5'd0);
                ex_illegal_o  <= illegal;
            end else if (ex_ready_i) begin
                ex_valid_o <= 1'b0;
            end
            if (hazard && stall_cnt_o != {STALL_CNT_W{1'b1}}) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decode_rf_issue.sv
// Directed bench for decode_rf_issue with a small register-file model on the id2rf port.
// Expectations adapt to WB_BYPASS_EN when that macro is defined.
module tb_decode_rf_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid_i;
    logic [31:0] if_instr_i;
    logic        id_ready_o;
    logic [4:0]  id2rf_rs1_addr_o, id2rf_rs2_addr_o;
    logic [31:0] rf2id_rs1_data_i, rf2id_rs2_data_i;
    logic        id2rf_rd_wr_req_o;
    logic [4:0]  id2rf_rd_addr_o;
    logic [31:0] id2rf_rd_data_o;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_addr_i;
    logic [31:0] wb_data_i;
    logic        ex_valid_o, ex_ready_i;
    logic [31:0] ex_instr_o, ex_rs1_data_o, ex_rs2_data_o;
    logic        ex_rd_we_o, ex_illegal_o;
    logic [15:0] stall_cnt_o;

    int n_cmp = 0;
    int n_err = 0;
    int exp_stall;

    always #5 clk = ~clk;

    decode_rf_issue #(.XLEN(32), .STALL_CNT_W(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .if_valid_i        (if_valid_i),
        .if_instr_i        (if_instr_i),
        .id_ready_o        (id_ready_o),
        .id2rf_rs1_addr_o  (id2rf_rs1_addr_o),
        .id2rf_rs2_addr_o  (id2rf_rs2_addr_o),
        .rf2id_rs1_data_i  (rf2id_rs1_data_i),
        .rf2id_rs2_data_i  (rf2id_rs2_data_i),
        .id2rf_rd_wr_req_o (id2rf_rd_wr_req_o),
        .id2rf_rd_addr_o   (id2rf_rd_addr_o),
        .id2rf_rd_data_o   (id2rf_rd_data_o),
        .wb_valid_i        (wb_valid_i),
        .wb_rd_addr_i      (wb_rd_addr_i),
        .wb_data_i         (wb_data_i),
        .ex_valid_o        (ex_valid_o),
        .ex_ready_i        (ex_ready_i),
        .ex_instr_o        (ex_instr_o),
        .ex_rs1_data_o     (ex_rs1_data_o),
        .ex_rs2_data_o     (ex_rs2_data_o),
        .ex_rd_we_o        (ex_rd_we_o),
        .ex_illegal_o      (ex_illegal_o),
        .stall_cnt_o       (stall_cnt_o)
    );

    // Register file model: x0 reads 0, others start at 0x1000+index.
    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'd0 : 32'h1000 + i;
        end else if (id2rf_rd_wr_req_o && id2rf_rd_addr_o != 5'd0) begin
            rf[id2rf_rd_addr_o] <= id2rf_rd_data_o;
        end
    end
    assign rf2id_rs1_data_i = rf[id2rf_rs1_addr_o];
    assign rf2id_rs2_data_i = rf[id2rf_rs2_addr_o];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        if_valid_i   = 1'b0;
        if_instr_i   = '0;
        wb_valid_i   = 1'b0;
        wb_rd_addr_i = '0;
        wb_data_i    = '0;
        ex_ready_i   = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check("rst_ex_valid", ex_valid_o, 0);
        check("rst_stall", stall_cnt_o, 0);
        check("rst_rs1_addr", id2rf_rs1_addr_o, 0);
        check("rst_rs2_addr", id2rf_rs2_addr_o, 0);
        check("rst_wr_req", id2rf_rd_wr_req_o, 0);
        check("rst_rd_addr", id2rf_rd_addr_o, 0);
        check("rst_ex_instr", ex_instr_o, 0);

        // addi x5,x0,1
        if_valid_i = 1'b1;
        if_instr_i = 32'h0010_0293;
        #1;
        check("addi_ready", id_ready_o, 1);
        check("addi_rs1_addr", id2rf_rs1_addr_o, 0);
        check("addi_rs2_addr_unused", id2rf_rs2_addr_o, 0);
        tick();
        // add x6,x5,x5 depends on x5
        if_instr_i = 32'h0052_8333;
        #1;
        check("addi_ex_valid", ex_valid_o, 1);
        check("addi_ex_instr", ex_instr_o, 32'h0010_0293);
        check("addi_ex_we", ex_rd_we_o, 1);
        check("addi_ex_rs1", ex_rs1_data_o, 0);
        check("addi_ex_illegal", ex_illegal_o, 0);
        check("raw_ready", id_ready_o, 0);
        check("raw_rs1_addr", id2rf_rs1_addr_o, 5);
        check("raw_rs2_addr", id2rf_rs2_addr_o, 5);
        check("raw_stall0", stall_cnt_o, 0);
        tick();
        check("raw_stall1", stall_cnt_o, 1);
        check("raw_ex_drained", ex_valid_o, 0);
        check("raw_ready1", id_ready_o, 0);
        tick();
        wb_valid_i   = 1'b1;
        wb_rd_addr_i = 5'd5;
        wb_data_i    = 32'd1;
        #1;
        check("raw_stall2", stall_cnt_o, 2);
        check("wb_req", id2rf_rd_wr_req_o, 1);
        check("wb_addr", id2rf_rd_addr_o, 5);
        check("wb_data", id2rf_rd_data_o, 1);
`ifdef WB_BYPASS_EN
        check("wb_cycle_ready", id_ready_o, 1);
        tick();
        wb_valid_i = 1'b0;
        if_valid_i = 1'b0;
        exp_stall  = 2;
`else
        check("wb_cycle_ready", id_ready_o, 0);
        tick();
        wb_valid_i = 1'b0;
        #1;
        check("post_wb_ready", id_ready_o, 1);
        check("post_wb_stall", stall_cnt_o, 3);
        tick();
        if_valid_i = 1'b0;
        exp_stall  = 3;
`endif
        #1;
        check("add_ex_valid", ex_valid_o, 1);
        check("add_ex_instr", ex_instr_o, 32'h0052_8333);
        check("add_ex_rs1", ex_rs1_data_o, 1);
        check("add_ex_rs2", ex_rs2_data_o, 1);
        check("add_ex_we", ex_rd_we_o, 1);

        // Backpressure: ID/EX held, no stall counting.
        ex_ready_i = 1'b0;
        if_valid_i = 1'b1;
        if_instr_i = 32'h0000_0013;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", id_ready_o, 0);
            check("bp_ex_valid", ex_valid_o, 1);
            check("bp_ex_instr", ex_instr_o, 32'h0052_8333);
            check("bp_ex_rs1", ex_rs1_data_o, 1);
            check("bp_stall", stall_cnt_o, exp_stall);
            tick();
        end
        ex_ready_i = 1'b1;
        #1;
        check("bp_release_ready", id_ready_o, 1);
        tick();
        check("nop_ex_instr", ex_instr_o, 32'h0000_0013);
        check("nop_ex_we", ex_rd_we_o, 0);
        if_instr_i = 32'hFFFF_FFFF;
        #1;
        check("ill_rs1_addr", id2rf_rs1_addr_o, 0);
        check("ill_ready", id_ready_o, 1);
        tick();
        // add x0,x31,x0: x31 must not have been marked by the illegal instruction.
        if_instr_i = 32'h000F_8033;
        #1;
        check("ill_ex_illegal", ex_illegal_o, 1);
        check("ill_ex_we", ex_rd_we_o, 0);
        check("x31_reader_ready", id_ready_o, 1);
        tick();
        wb_valid_i   = 1'b1;
        wb_rd_addr_i = 5'd0;
        wb_data_i    = 32'hDEAD_BEEF;
        if_instr_i   = 32'h0000_0033;
        #1;
        check("wb_x0_req", id2rf_rd_wr_req_o, 1);
        check("wb_x0_addr", id2rf_rd_addr_o, 0);
        check("wb_x0_data", id2rf_rd_data_o, 32'hDEAD_BEEF);
        check("x0_reader_ready", id_ready_o, 1);
        tick();
        wb_valid_i = 1'b0;
        // add x0,x6,x0: x6 still pending from the earlier add.
        if_instr_i = 32'h0003_0033;
        #1;
        check("x6_pending_ready", id_ready_o, 0);
        tick();
        if_instr_i = 32'h0010_0293;
        #1;
        check("addi2_ready", id_ready_o, 1);
        tick();
        if_valid_i = 1'b0;
        ex_ready_i = 1'b0;
        #1;
        check("pre_rst_ex_valid", ex_valid_o, 1);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_ex_valid", ex_valid_o, 0);
        check("async_rst_stall", stall_cnt_o, 0);
        check("async_rst_ex_instr", ex_instr_o, 0);
        #1;
        reset      = 1'b0;
        if_valid_i = 1'b1;
        if_instr_i = 32'h0052_8333;
        ex_ready_i = 1'b1;
        #1;
        check("post_rst_x5_ready", id_ready_o, 1);
        tick();
        check("post_rst_ex_valid", ex_valid_o, 1);
        check("post_rst_ex_instr", ex_instr_o, 32'h0052_8333);
        if_valid_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_rf_issue.md
Name: decode_rf_issue

Overview:
- Decode/issue stage that acts as the initiator on the id2rf register-file interface.
- Accepts instructions from fetch, decodes operand usage, and drives rs1/rs2 read addresses.
- Tracks outstanding destination writes in a 32-entry scoreboard and stalls on hazards.
- Forwards writeback requests onto the rf write port and registers operands into an ID/EX output stage with a valid/ready handshake.

Parameters:
- XLEN, 32, data width of register operands and instruction.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_valid_i  in  1  fetch presents an instruction.
- if_instr_i  in  XLEN  instruction word.
- id_ready_o  out  1  decode accepts the instruction this cycle.
- id2rf_rs1_addr_o  out  5  rf read address 1.
- id2rf_rs2_addr_o  out  5  rf read address 2.
- rf2id_rs1_data_i  in  XLEN  combinational rf read data 1.
- rf2id_rs2_data_i  in  XLEN  combinational rf read data 2.
- id2rf_rd_wr_req_o  out  1  rf write request.
- id2rf_rd_addr_o  out  5  rf write address.
- id2rf_rd_data_o  out  XLEN  rf write data.
- wb_valid_i  in  1  writeback stage retires a result; always accepted.
- wb_rd_addr_i  in  5  writeback destination.
- wb_data_i  in  XLEN  writeback data.
- ex_valid_o  out  1  ID/EX register holds a valid instruction.
- ex_ready_i  in  1  execute consumes ID/EX this cycle.
- ex_instr_o  out  XLEN  registered instruction.
- ex_rs1_data_o  out  XLEN  registered operand 1.
- ex_rs2_data_o  out  XLEN  registered operand 2.
- ex_rd_we_o  out  1  registered "instruction writes rd".
- ex_illegal_o  out  1  registered unknown-opcode flag.
- stall_cnt_o  out  STALL_CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: ex_valid_o=0, all ex_* data outputs=0, scoreboard=0, stall_cnt_o=0. Reset mid-operation drops any in-flight ID/EX contents.
- Field decode: rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0].
- Operand usage by opcode (use1/use2/we):
  - 0110011: 1/1/1
  - 0010011, 0000011, 1100111: 1/0/1
  - 0100011, 1100011: 1/1/0
  - 0110111, 0010111, 1101111: 0/0/1
  - any other opcode: 0/0/0, illegal=1
- Read addresses: id2rf_rs*_addr_o equal the field when used and if_valid_i=1; otherwise 0. The rf read is combinational, so operands are available in the same cycle.
- Pending bits: pend(r) = scoreboard[r] && r!=0. x0 is never pending.
- Hazard condition: hazard = if_valid_i && ((use1 && pend(rs1)) || (use2 && pend(rs2)) || (we && pend(rd))). The rd term covers WAW.
- Handshake: id_ready_o = !hazard && (!ex_valid_o || ex_ready_i). The instruction is accepted when if_valid_i && id_ready_o.
- On accept, next cycle: ex_valid_o=1, and ex_* capture the instruction, rf data, we (forced to 0 when rd==0) and illegal. Latency fetch-to-EX is 1 cycle.
- Not accepted but ex_ready_i=1: ex_valid_o goes to 0.
- Not accepted and ex_ready_i=0: ID/EX holds its contents stable.
- Writeback: id2rf_rd_wr_req_o=wb_valid_i, id2rf_rd_addr_o=wb_rd_addr_i, id2rf_rd_data_o=wb_data_i, all combinational passthrough.
- Scoreboard set/clear:
  - Clear scoreboard[wb_rd_addr_i] when wb_valid_i=1.
  - Set scoreboard[rd] on accept when we && rd!=0.
  - Set and clear on the same index in the same cycle: set wins.
- stall_cnt_o increments each cycle hazard=1 and saturates at all-ones. Backpressure from ex_ready_i alone does not count.
- Writeback to a register that is not pending: clear is a no-op; no error.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - pend(r) additionally requires !(wb_valid_i && wb_rd_addr_i==r).
  - When wb_valid_i && wb_rd_addr_i==rs1 && rs1!=0, operand 1 captures wb_data_i instead of rf2id_rs1_data_i; same for rs2.
  - Effect: a RAW dependence resolves in the writeback cycle itself.
- Undefined: the scoreboard alone governs hazards. A dependent instruction issues the cycle after writeback and reads the updated rf value.

Test Plan:
- Reset released, if_valid_i=0 -> ex_valid_o=0, stall_cnt_o=0, all id2rf outputs 0.
- Issue addi x5,x0,1 (0x00100293), then add x6,x5,x5 (0x00528333) with no writeback -> second instruction stalls: id_ready_o=0, stall_cnt_o increments each cycle.
- Continue the previous case with wb_valid_i=1, x5, 0x1:
  - Without bypass: id_ready_o rises the next cycle and ex_rs1_data_o=ex_rs2_data_o=1.
  - With WB_BYPASS_EN: issue happens in the writeback cycle itself with operands=1.
- ex_ready_i=0 for 3 cycles while ex_valid_o=1 -> ex_* outputs stable, id_ready_o=0, stall_cnt_o unchanged.
- Instruction 0xFFFFFFFF -> ex_illegal_o=1, ex_rd_we_o=0, no scoreboard bit set.
- Writes to x0:
  - Instruction with rd=x0 (0x00000013) -> no scoreboard bit set.
  - wb_valid_i to x0 -> id2rf_rd_wr_req_o=1, addr=0.
  - A following reader of x0 never stalls.
- Assert reset asynchronously with scoreboard[5]=1 and ex_valid_o=1 -> both clear immediately; a post-reset reader of x5 issues without stall.
